alu_muldiv_control: RTL and testbench
=====================================

# alu_muldiv_control

Parametrised successor to the multicycle datapath's ALU control stage. It decodes `aluop`/`funct` into single-cycle ALU results, and adds an iterative HI/LO multiply/divide engine with a start/busy/done handshake. The FSM execute state drives it: single-cycle ops return a result combinationally, while mult/div stall the FSM until `done`.

## Interface
- `WIDTH`, default 32: datapath width. Must be ≥4.
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `aluop`  in  6  operation class from main control.
- `funct`  in  6  instruction funct field; used when `aluop`=000010.
- `src1`, `src2`  in  WIDTH  operands.
- `start`  in  1  one-cycle request for HI/LO ops (mult*, div*, mthi, mtlo).
- `result`  out  WIDTH  combinational ALU result.
- `zero`  out  1  `result`==0.
- `overflow`  out  1  signed overflow of add/sub (funct 100000/100010 only).
- `busy`  out  1  mult/div in progress.
- `done`  out  1  one-cycle pulse when HI/LO are updated by mult/div.
- `hi`, `lo`  out  WIDTH  HI/LO registers.

## Operation
- `aluop` decode:
  - 000000 add
  - 000001 sub
  - 000010 R-type per `funct`
  - 000011 and
  - 000100 or
  - 000101 slt (signed)
  - 000110 sltu
  - 000111 lui, giving `src2`<<16 (WIDTH≥17 only; otherwise 0)
  - others give `result`=0
- `funct` decode:
  - add 100000, addu 100001, sub 100010, subu 100011
  - and 100100, or 100101, xor 100110, nor 100111
  - slt 101010, sltu 101011
  - mfhi 010000 (`result`=`hi`), mflo 010010 (`result`=`lo`)
  - mthi 010001, mtlo 010011
  - mult 011000, multu 011001, div 011010, divu 011011
  - unknown funct gives `result`=0
- Arithmetic is modulo 2^WIDTH. `overflow` = operand signs equal (add) or differ (sub), and the result sign differs from `src1`. `overflow` is 0 for all other ops.
- The slt family returns 1 or 0, zero-extended to WIDTH.
- `start` is accepted only when `busy`=0, `aluop`=000010, and `funct` is a HI/LO op. Otherwise it is ignored with no state change.
- mthi/mtlo: `hi`/`lo` loads `src1` at the accepting edge. No `busy`, no `done`.
- FSM states:
  - IDLE: on a mult/div start, latch operands (absolute values and result signs for signed ops) and go to RUN.
  - RUN: one shift-add (mult) or restoring-subtract (div) step per cycle. A counter runs 0..WIDTH-1, then the FSM goes to FIX.
  - FIX: apply sign correction, write `hi`/`lo`, go to IDLE.
- Results:
  - mult/multu: {hi,lo} = full 2·WIDTH product.
  - div/divu: lo = quotient, hi = remainder. Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divide by zero (any signedness): lo = all ones, hi = `src1`. No trap.
  - Signed MIN/−1: lo = MIN, hi = 0.
- `result`, `zero`, and `overflow` stay valid combinationally during `busy`. mfhi/mflo return the old `hi`/`lo` until FIX.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, FSM=IDLE, counter=0.
- Start sampled at edge k:
  - `busy` rises after edge k.
  - RUN steps occur at edges k+1..k+WIDTH.
  - FIX writes `hi`/`lo` at edge k+WIDTH+1.
  - After that edge, `busy`=0 and `done`=1 for exactly one cycle.
  - Total latency is WIDTH+1 cycles.
- A new start is accepted in the same cycle `done`=1. Back-to-back ops have no gap.
- Reset asserted mid-operation aborts immediately. `hi`/`lo` are cleared and no `done` is issued.
- `start` while `busy` is ignored and does not extend or restart the operation.

## Test plan
- Reset mid-RUN, 5 cycles after a mult start: `busy`, `done`, `hi`, `lo` all go to 0 asynchronously. The next start runs normally.
- ALU ops, no start:
  - aluop 000010, funct 100000, src1=0x7FFFFFFF, src2=1: `result`=0x80000000, `overflow`=1, `zero`=0.
  - funct 100011, 5−5: `result`=0, `zero`=1.
  - funct 101011, src1=1, src2=0xFFFFFFFF: `result`=1.
- mult, src1=0xFFFFFFFE (−2), src2=3, start at edge k: `busy` for 33 cycles, `done` pulse after edge k+33, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. multu with the same operands: `hi`=2, `lo`=0xFFFFFFFA.
- div, src1=−7 (0xFFFFFFF9), src2=2: `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - divu 7/0: `lo`=0xFFFFFFFF, `hi`=7.
  - div 0x80000000/−1: `lo`=0x80000000, `hi`=0.
- Start during `busy` is ignored: `done` arrives at the original time with the original result. mthi 0x1234 then mfhi: `result`=0x1234, `done` stays 0.

Source files
------------

// File: rtl/alu_muldiv_control.sv
// ============================================================================
// Module      : alu_muldiv_control
// Description : ALU control/decode with single-cycle results plus an iterative
//               HI/LO multiply/divide engine using a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_muldiv_control #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             start,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] c_OP_ADD  = 6'b000000;
    localparam logic [5:0] c_OP_SUB  = 6'b000001;
    localparam logic [5:0] c_OP_R    = 6'b000010;
    localparam logic [5:0] c_OP_AND  = 6'b000011;
    localparam logic [5:0] c_OP_OR   = 6'b000100;
    localparam logic [5:0] c_OP_SLT  = 6'b000101;
    localparam logic [5:0] c_OP_SLTU = 6'b000110;
    localparam logic [5:0] c_OP_LUI  = 6'b000111;

    localparam logic [5:0] c_F_ADD   = 6'b100000;
    localparam logic [5:0] c_F_ADDU  = 6'b100001;
    localparam logic [5:0] c_F_SUB   = 6'b100010;
    localparam logic [5:0] c_F_SUBU  = 6'b100011;
    localparam logic [5:0] c_F_AND   = 6'b100100;
    localparam logic [5:0] c_F_OR    = 6'b100101;
    localparam logic [5:0] c_F_XOR   = 6'b100110;
    localparam logic [5:0] c_F_NOR   = 6'b100111;
    localparam logic [5:0] c_F_SLT   = 6'b101010;
    localparam logic [5:0] c_F_SLTU  = 6'b101011;
    localparam logic [5:0] c_F_MFHI  = 6'b010000;
    localparam logic [5:0] c_F_MTHI  = 6'b010001;
    localparam logic [5:0] c_F_MFLO  = 6'b010010;
    localparam logic [5:0] c_F_MTLO  = 6'b010011;
    localparam logic [5:0] c_F_MULT  = 6'b011000;
    localparam logic [5:0] c_F_MULTU = 6'b011001;
    localparam logic [5:0] c_F_DIV   = 6'b011010;
    localparam logic [5:0] c_F_DIVU  = 6'b011011;

    localparam int c_CW = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t r_state, w_next;

    logic [WIDTH-1:0] r_hi, r_lo, r_acc, r_mq, r_md, r_src1;
    logic [c_CW-1:0]  r_cnt;
    logic             r_neg_q, r_neg_r, r_is_div, r_dz, r_done;

    // ---------------------------------------------------------------- ALU
    logic [WIDTH-1:0] w_add, w_sub, w_lui, w_result;
    logic             w_ovf_add, w_ovf_sub, w_slt, w_sltu, w_ovf;

    assign w_add     = src1 + src2;
    assign w_sub     = src1 - src2;
    assign w_ovf_add = (src1[WIDTH-1] == src2[WIDTH-1]) && (w_add[WIDTH-1] != src1[WIDTH-1]);
    assign w_ovf_sub = (src1[WIDTH-1] != src2[WIDTH-1]) && (w_sub[WIDTH-1] != src1[WIDTH-1]);
    assign w_slt     = $signed(src1) < $signed(src2);
    assign w_sltu    = src1 < src2;

    generate
        if (WIDTH >= 17) begin : g_lui
            assign w_lui = src2 << 16;
        end else begin : g_no_lui
            assign w_lui = '0;
        end
    endgenerate

    always_comb begin
        w_result = '0;
        w_ovf    = 1'b0;
        case (aluop)
            c_OP_ADD:  w_result = w_add;
            c_OP_SUB:  w_result = w_sub;
            c_OP_AND:  w_result = src1 & src2;
            c_OP_OR:   w_result = src1 | src2;
            c_OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_slt};
            c_OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, w_sltu};
            c_OP_LUI:  w_result = w_lui;
            c_OP_R: begin
                case (funct)
                    c_F_ADD:  begin w_result = w_add; w_ovf = w_ovf_add; end
                    c_F_ADDU: w_result = w_add;
                    c_F_SUB:  begin w_result = w_sub; w_ovf = w_ovf_sub; end
                    c_F_SUBU: w_result = w_sub;
                    c_F_AND:  w_result = src1 & src2;
                    c_F_OR:   w_result = src1 | src2;
                    c_F_XOR:  w_result = src1 ^ src2;
                    c_F_NOR:  w_result = ~(src1 | src2);
                    c_F_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_slt};
                    c_F_SLTU: w_result = {{(WIDTH-1){1'b0}}, w_sltu};
                    c_F_MFHI: w_result = r_hi;
                    c_F_MFLO: w_result = r_lo;
                    default:  w_result = '0;
                endcase
            end
            default: w_result = '0;
        endcase
    end

    assign result   = w_result;
    assign zero     = (w_result == '0);
    assign overflow = w_ovf;

    // ---------------------------------------------------------- handshake
    logic w_hilo, w_muldiv, w_accept, w_md_start, w_signed, w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_abs_a, w_abs_b;

    always_comb begin
        w_hilo   = 1'b0;
        w_muldiv = 1'b0;
        case (funct)
            c_F_MTHI, c_F_MTLO: w_hilo = 1'b1;
            c_F_MULT, c_F_MULTU, c_F_DIV, c_F_DIVU: begin
                w_hilo   = 1'b1;
                w_muldiv = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy       = (r_state != S_IDLE);
    assign w_accept   = start && !busy && (aluop == c_OP_R) && w_hilo;
    assign w_md_start = w_accept && w_muldiv;
    assign w_signed   = (funct == c_F_MULT) || (funct == c_F_DIV);
    assign w_a_neg    = w_signed && src1[WIDTH-1];
    assign w_b_neg    = w_signed && src2[WIDTH-1];
    assign w_abs_a    = w_a_neg ? -src1 : src1;
    assign w_abs_b    = w_b_neg ? -src2 : src2;

    // ------------------------------------------------------------- engine
    logic [WIDTH:0]     w_sum, w_shl;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_prod, w_prod_s;
    logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;

    assign w_sum = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_md} : {(WIDTH+1){1'b0}});
    assign w_shl = {r_acc, r_mq[WIDTH-1]};
    assign w_ge  = (w_shl >= {1'b0, r_md});

    assign w_prod   = {r_acc, r_mq};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;

    // Divide-by-zero bypasses sign fixing so HI returns the raw dividend.
    always_comb begin
        w_fix_hi = w_prod_s[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod_s[WIDTH-1:0];
        if (r_is_div) begin
            if (r_dz) begin
                w_fix_hi = r_src1;
                w_fix_lo = '1;
            end else begin
                w_fix_hi = r_neg_r ? -r_acc : r_acc;
                w_fix_lo = r_neg_q ? -r_mq : r_mq;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_md_start) w_next = S_RUN;
            S_RUN:   if (r_cnt == c_LAST) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc    <= '0;
            r_mq     <= '0;
            r_md     <= '0;
            r_src1   <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIX);
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_md_start) begin
                        r_acc    <= '0;
                        r_mq     <= w_abs_a;
                        r_md     <= w_abs_b;
                        r_src1   <= src1;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_is_div <= (funct == c_F_DIV) || (funct == c_F_DIVU);
                        r_dz     <= (src2 == '0);
                    end else if (w_accept && funct == c_F_MTHI) begin
                        r_hi <= src1;
                    end else if (w_accept && funct == c_F_MTLO) begin
                        r_lo <= src1;
                    end
                end
                S_RUN: begin
                    r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
                    if (r_is_div) begin
                        r_acc <= w_ge ? (w_shl[WIDTH-1:0] - r_md) : w_shl[WIDTH-1:0];
                        r_mq  <= {r_mq[WIDTH-2:0], w_ge};
                    end else begin
                        r_acc <= w_sum[WIDTH:1];
                        r_mq  <= {w_sum[0], r_mq[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    r_hi <= w_fix_hi;
                    r_lo <= w_fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_alu_muldiv_control.sv
// ============================================================================
// Module      : tb_alu_muldiv_control
// Description : Directed self-checking bench for alu_muldiv_control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_muldiv_control;

    localparam int WIDTH = 32;

    localparam logic [5:0] c_R     = 6'b000010;
    localparam logic [5:0] c_MULT  = 6'b011000;
    localparam logic [5:0] c_MULTU = 6'b011001;
    localparam logic [5:0] c_DIV   = 6'b011010;
    localparam logic [5:0] c_DIVU  = 6'b011011;
    localparam logic [5:0] c_MTHI  = 6'b010001;
    localparam logic [5:0] c_MTLO  = 6'b010011;
    localparam logic [5:0] c_MFHI  = 6'b010000;
    localparam logic [5:0] c_MFLO  = 6'b010010;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       aluop, funct;
    logic [WIDTH-1:0] src1, src2;
    logic             start;
    logic [WIDTH-1:0] result, hi, lo;
    logic             zero, overflow, busy, done;

    int n_vec = 0;
    int n_err = 0;

    alu_muldiv_control #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .aluop    (aluop),
        .funct    (funct),
        .src1     (src1),
        .src2     (src2),
        .start    (start),
        .result   (result),
        .zero     (zero),
        .overflow (overflow),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic alu(input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        aluop = op; funct = fn; src1 = a; src2 = b;
        #1;
    endtask

    task automatic start_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        aluop = c_R; funct = fn; src1 = a; src2 = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_busy(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("busy_run", {31'd0, busy}, 32'd1);
            check("done_early", {31'd0, done}, 32'd0);
        end
    endtask

    task automatic expect_done();
        @(posedge clk);
        #1;
        check("busy_end", {31'd0, busy}, 32'd0);
        check("done_pulse", {31'd0, done}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; aluop = '0; funct = '0; src1 = '0; src2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single-cycle ALU
        alu(c_R, 6'b100000, 32'h7FFFFFFF, 32'd1);
        check("add_res", result, 32'h80000000);
        check("add_ovf", {31'd0, overflow}, 32'd1);
        check("add_zero", {31'd0, zero}, 32'd0);
        alu(c_R, 6'b100011, 32'd5, 32'd5);
        check("subu_res", result, 32'd0);
        check("subu_zero", {31'd0, zero}, 32'd1);
        check("subu_ovf", {31'd0, overflow}, 32'd0);
        alu(c_R, 6'b101011, 32'd1, 32'hFFFFFFFF);
        check("sltu", result, 32'd1);
        alu(c_R, 6'b101010, 32'd1, 32'hFFFFFFFF);
        check("slt", result, 32'd0);
        alu(c_R, 6'b100010, 32'h80000000, 32'd1);
        check("sub_ovf", {31'd0, overflow}, 32'd1);
        check("sub_res", result, 32'h7FFFFFFF);
        alu(c_R, 6'b100111, 32'h0F0F0000, 32'h000000F0);
        check("nor", result, 32'hF0F0FF0F);
        alu(6'b000111, 6'd0, 32'd0, 32'h00001234);
        check("lui", result, 32'h12340000);
        alu(6'b000001, 6'd0, 32'd3, 32'd5);
        check("aluop_sub", result, 32'hFFFFFFFE);
        check("aluop_sub_ovf", {31'd0, overflow}, 32'd0);
        alu(6'b000101, 6'd0, 32'hFFFFFFFF, 32'd1);
        check("aluop_slt", result, 32'd1);
        alu(6'b111111, 6'd0, 32'd9, 32'd9);
        check("bad_aluop", result, 32'd0);
        check("bad_aluop_zero", {31'd0, zero}, 32'd1);
        alu(c_R, 6'b111111, 32'd9, 32'd9);
        check("bad_funct", result, 32'd0);

        // mult -2 * 3 with full timing, then multu back-to-back
        start_op(c_MULT, 32'hFFFFFFFE, 32'd3);
        check("mult_busy_k", {31'd0, busy}, 32'd1);
        wait_busy(WIDTH);
        expect_done();
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFA);
        start_op(c_MULTU, 32'hFFFFFFFE, 32'd3);
        check("multu_busy_k", {31'd0, busy}, 32'd1);
        check("multu_done_drop", {31'd0, done}, 32'd0);
        wait_busy(WIDTH);
        expect_done();
        check("multu_hi", hi, 32'd2);
        check("multu_lo", lo, 32'hFFFFFFFA);
        funct = c_MFLO;
        #1;
        check("mflo", result, 32'hFFFFFFFA);

        // Divides
        start_op(c_DIV, 32'hFFFFFFF9, 32'd2);
        wait_busy(WIDTH);
        expect_done();
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);
        start_op(c_DIVU, 32'd7, 32'd0);
        wait_busy(WIDTH);
        expect_done();
        check("divu0_lo", lo, 32'hFFFFFFFF);
        check("divu0_hi", hi, 32'd7);
        start_op(c_DIV, 32'hFFFFFFF9, 32'd0);
        wait_busy(WIDTH);
        expect_done();
        check("div0_lo", lo, 32'hFFFFFFFF);
        check("div0_hi", hi, 32'hFFFFFFF9);
        start_op(c_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_busy(WIDTH);
        expect_done();
        check("divmin_lo", lo, 32'h80000000);
        check("divmin_hi", hi, 32'd0);

        // Start while busy is ignored; mflo shows old LO until FIX
        start_op(c_DIVU, 32'd100, 32'd7);
        wait_busy(3);
        funct = c_MULT; src1 = 32'd5; src2 = 32'd5; start = 1'b1;
        wait_busy(1);
        start = 1'b0; funct = c_MFLO;
        #1;
        check("mflo_busy", result, 32'h80000000);
        wait_busy(WIDTH - 4);
        expect_done();
        check("ign_lo", lo, 32'd14);
        check("ign_hi", hi, 32'd2);
        @(posedge clk);
        #1;
        check("ign_done_clr", {31'd0, done}, 32'd0);
        check("ign_busy_clr", {31'd0, busy}, 32'd0);

        // mthi / mtlo: no busy, no done
        start_op(c_MTHI, 32'h00001234, 32'd0);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        check("mthi_done", {31'd0, done}, 32'd0);
        funct = c_MFHI;
        #1;
        check("mfhi", result, 32'h00001234);
        start_op(c_MTLO, 32'h00005678, 32'd0);
        check("mtlo_lo", lo, 32'h00005678);
        @(posedge clk);
        #1;
        check("mtlo_done", {31'd0, done}, 32'd0);

        // Asynchronous reset mid-RUN
        start_op(c_MULT, 32'd3, 32'd5);
        wait_busy(5);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        start_op(c_MULTU, 32'd3, 32'd5);
        check("post_busy", {31'd0, busy}, 32'd1);
        wait_busy(WIDTH);
        expect_done();
        check("post_hi", hi, 32'd0);
        check("post_lo", lo, 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
